// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program into instruction memory, holds the
// core in reset while loading, releases it for a bounded or unbounded run,
// and parks in HALT until restarted.
module imem_boot_loader #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned DEPTH           = 256,
  parameter int unsigned ADDR_W          = $clog2(DEPTH),
  parameter int unsigned CORE_RST_CYCLES = 2,
  parameter int unsigned RUN_CYCLES      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              halt_req,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_reset,
  output logic              running,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   words_loaded,
  output logic [31:0]       run_count
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned REL_W = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;

  // Last writable slot; a non-final word landing here ends the load.
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);
  localparam logic [REL_W-1:0] REL_LAST  = REL_W'(CORE_RST_CYCLES - 1);
  localparam logic [31:0]      RUN_LAST  = 32'(RUN_CYCLES - 1);
  localparam bit               RUN_BOUND = (RUN_CYCLES != 0);

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t            state;
  logic [REL_W-1:0]  rel_cnt;

  // Sequencer: state, write port, status flags and counters all update here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LOAD;
      rel_cnt      <= '0;
      in_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      core_reset   <= 1'b1;
      running      <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      words_loaded <= '0;
      run_count    <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_LOAD: begin
          if (in_valid) begin
            mem_we       <= 1'b1;
            mem_addr     <= words_loaded[ADDR_W-1:0];
            mem_wdata    <= in_data;
            words_loaded <= words_loaded + CNT_W'(1);
            if (in_last || (words_loaded == LAST_SLOT)) begin
              state    <= S_RELEASE;
              in_ready <= 1'b0;
              rel_cnt  <= '0;
              // Only reachable without in_last when the memory filled up.
              overflow <= ~in_last;
            end
          end
        end
        S_RELEASE: begin
          if (rel_cnt == REL_LAST) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt + REL_W'(1);
          end
        end
        S_RUN: begin
          if (halt_req || (RUN_BOUND && (run_count == RUN_LAST))) begin
            state      <= S_HALT;
            running    <= 1'b0;
            done       <= 1'b1;
            core_reset <= 1'b1;
          end else if (run_count != '1) begin
            run_count <= run_count + 32'(1);
          end
        end
        S_HALT: begin
          if (restart) begin
            state        <= S_LOAD;
            in_ready     <= 1'b1;
            done         <= 1'b0;
            overflow     <= 1'b0;
            words_loaded <= '0;
            run_count    <= '0;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: randomized load/run/halt stimulus on two loader
// instances (large memory with a run budget, tiny memory unbounded) with a
// write scoreboard fed from a program-level model.
module tb_imem_boot_loader;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEP_A = 256;
  localparam int unsigned AW_A  = 8;
  localparam int unsigned DEP_B = 4;
  localparam int unsigned AW_B  = 2;
  localparam int unsigned RST_C = 2;
  localparam int unsigned RUN_A = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic          rst      [2];
  logic          in_valid [2];
  logic [DW-1:0] in_data  [2];
  logic          in_last  [2];
  logic          halt_req [2];
  logic          restart  [2];

  logic            in_ready_a, mem_we_a, core_reset_a, running_a, done_a, overflow_a;
  logic [AW_A-1:0] mem_addr_a;
  logic [DW-1:0]   mem_wdata_a;
  logic [AW_A:0]   wl_a;
  logic [31:0]     rc_a;
  logic            in_ready_b, mem_we_b, core_reset_b, running_b, done_b, overflow_b;
  logic [AW_B-1:0] mem_addr_b;
  logic [DW-1:0]   mem_wdata_b;
  logic [AW_B:0]   wl_b;
  logic [31:0]     rc_b;

  imem_boot_loader #(.DATA_W(DW), .DEPTH(DEP_A), .ADDR_W(AW_A),
                     .CORE_RST_CYCLES(RST_C), .RUN_CYCLES(RUN_A)) dut_a (
    .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready_a),
    .in_data(in_data[0]), .in_last(in_last[0]), .halt_req(halt_req[0]),
    .restart(restart[0]), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .core_reset(core_reset_a), .running(running_a),
    .done(done_a), .overflow(overflow_a), .words_loaded(wl_a), .run_count(rc_a));

  imem_boot_loader #(.DATA_W(DW), .DEPTH(DEP_B), .ADDR_W(AW_B),
                     .CORE_RST_CYCLES(RST_C), .RUN_CYCLES(0)) dut_b (
    .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready_b),
    .in_data(in_data[1]), .in_last(in_last[1]), .halt_req(halt_req[1]),
    .restart(restart[1]), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .core_reset(core_reset_b), .running(running_b),
    .done(done_b), .overflow(overflow_b), .words_loaded(wl_b), .run_count(rc_b));

  // Per-instance views so tasks can be indexed by instance number.
  logic        in_ready_v[2], mem_we_v[2], core_reset_v[2], running_v[2], done_v[2], overflow_v[2];
  logic [31:0] addr_v[2], wdata_v[2], wl_v[2], rc_v[2];
  assign in_ready_v[0]   = in_ready_a;    assign in_ready_v[1]   = in_ready_b;
  assign mem_we_v[0]     = mem_we_a;      assign mem_we_v[1]     = mem_we_b;
  assign core_reset_v[0] = core_reset_a;  assign core_reset_v[1] = core_reset_b;
  assign running_v[0]    = running_a;     assign running_v[1]    = running_b;
  assign done_v[0]       = done_a;        assign done_v[1]       = done_b;
  assign overflow_v[0]   = overflow_a;    assign overflow_v[1]   = overflow_b;
  assign addr_v[0]       = 32'(mem_addr_a); assign addr_v[1]     = 32'(mem_addr_b);
  assign wdata_v[0]      = mem_wdata_a;   assign wdata_v[1]      = mem_wdata_b;
  assign wl_v[0]         = 32'(wl_a);     assign wl_v[1]         = 32'(wl_b);
  assign rc_v[0]         = rc_a;          assign rc_v[1]         = rc_b;

  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [31:0] prog[$];

  int n_wr[2]        = '{0, 0};
  int last_wr_cyc[2] = '{0, 0};
  int run_start[2]   = '{0, 0};
  logic run_prev[2]  = '{1'b0, 1'b0};

  task automatic chk(int k, string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s actual=%0h required=%0h", k, name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_exp(int k, logic [31:0] a, logic [31:0] d);
    if (k == 0) q0.push_back({a, d});
    else        q1.push_back({a, d});
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_we_v[k]) begin
        logic [63:0] e;
        bit          have;
        have = 1'b0;
        e    = '0;
        if (k == 0) begin
          if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
        end else begin
          if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
        end
        n_wr[k]        <= n_wr[k] + 1;
        last_wr_cyc[k] <= cyc;
        chk(k, "write_expected", 64'(have), 64'(1));
        if (have) begin
          chk(k, "wr_addr", 64'(addr_v[k]), 64'(e[63:32]));
          chk(k, "wr_data", 64'(wdata_v[k]), 64'(e[31:0]));
        end
      end
      if (running_v[k] && !run_prev[k]) run_start[k] <= cyc;
      run_prev[k] <= running_v[k];
    end
  end

  task automatic check_reset(int k);
    chk(k, "rst_in_ready",   64'(in_ready_v[k]),   64'(1));
    chk(k, "rst_mem_we",     64'(mem_we_v[k]),     64'(0));
    chk(k, "rst_mem_addr",   64'(addr_v[k]),       64'(0));
    chk(k, "rst_mem_wdata",  64'(wdata_v[k]),      64'(0));
    chk(k, "rst_core_reset", 64'(core_reset_v[k]), 64'(1));
    chk(k, "rst_running",    64'(running_v[k]),    64'(0));
    chk(k, "rst_done",       64'(done_v[k]),       64'(0));
    chk(k, "rst_overflow",   64'(overflow_v[k]),   64'(0));
    chk(k, "rst_words",      64'(wl_v[k]),         64'(0));
    chk(k, "rst_run_count",  64'(rc_v[k]),         64'(0));
  endtask

  // Offer one word; acc reports whether a handshake happened within budget.
  task automatic send(int k, logic [31:0] w, bit last, int gap, int budget, output bit acc);
    acc = 1'b0;
    repeat (gap) tick();
    in_valid[k] = 1'b1;
    in_data[k]  = w;
    in_last[k]  = last;
    for (int i = 0; i < budget && !acc; i++) begin
      if (in_ready_v[k]) acc = 1'b1;
      tick();
    end
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
  endtask

  // Program model: word i lands at address i while i < depth, else refused.
  task automatic load_prog(int k, int n, bit with_last, int depth, int gapmode, int abort_at);
    bit acc;
    int gap;
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        in_valid[k] = 1'b1;
        in_data[k]  = prog[i];
        rst[k]      = 1'b1;
        tick();
        check_reset(k);
        in_valid[k] = 1'b0;
        rst[k]      = 1'b0;
        return;
      end
      gap = (gapmode == 0) ? 0 : ((gapmode == 1) ? 1 : int'($urandom_range(0, 2)));
      if (i < depth) push_exp(k, 32'(i), prog[i]);
      send(k, prog[i], with_last && (i == n - 1), gap, (i < depth) ? 40 : 6, acc);
      chk(k, "accept", 64'(acc), 64'(i < depth));
    end
  endtask

  task automatic wait_running(int k);
    int n = 0;
    while (!running_v[k] && n < 50) begin
      tick();
      n++;
    end
    chk(k, "run_entered", 64'(running_v[k]), 64'(1));
  endtask

  task automatic pulse_restart(int k);
    restart[k] = 1'b1;
    tick();
    restart[k] = 1'b0;
  endtask

  initial begin
    int t0, base, n, j, e, len;
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; in_valid[k] = 1'b0; in_data[k] = '0; in_last[k] = 1'b0;
      halt_req[k] = 1'b0; restart[k] = 1'b0;
    end
    prog = '{32'h3e800093, 32'h00300113, 32'h00000193, 32'h00000213,
             32'h00220863, 32'h001181b3, 32'h00120213, 32'hff5ff36f};
    tick(); tick();
    check_reset(0);
    check_reset(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    // Back-to-back load of the reference program, then budgeted run.
    t0   = cyc;
    base = n_wr[0];
    load_prog(0, 8, 1'b1, DEP_A, 0, -1);
    chk(0, "in_ready_after_last", 64'(in_ready_v[0]), 64'(0));
    chk(0, "writes_count", 64'(n_wr[0] - base), 64'(8));
    chk(0, "writes_consecutive", 64'(last_wr_cyc[0] - t0), 64'(8));
    chk(0, "words_loaded", 64'(wl_v[0]), 64'(8));
    chk(0, "overflow", 64'(overflow_v[0]), 64'(0));
    chk(0, "core_reset_in_release", 64'(core_reset_v[0]), 64'(1));
    wait_running(0);
    chk(0, "release_len", 64'(run_start[0] - last_wr_cyc[0]), 64'(RST_C));
    chk(0, "core_reset_run", 64'(core_reset_v[0]), 64'(0));
    n = 0;
    while (running_v[0] && n < 100) begin
      n++;
      tick();
    end
    chk(0, "run_len", 64'(n), 64'(RUN_A));
    chk(0, "done", 64'(done_v[0]), 64'(1));
    chk(0, "core_reset_halt", 64'(core_reset_v[0]), 64'(1));
    chk(0, "run_count_final", 64'(rc_v[0]), 64'(RUN_A - 1));
    halt_req[0] = 1'b1;
    repeat (3) tick();
    halt_req[0] = 1'b0;
    chk(0, "run_count_held", 64'(rc_v[0]), 64'(RUN_A - 1));
    chk(0, "words_held", 64'(wl_v[0]), 64'(8));
    chk(0, "done_held", 64'(done_v[0]), 64'(1));

    pulse_restart(0);
    chk(0, "restart_in_ready", 64'(in_ready_v[0]), 64'(1));
    chk(0, "restart_words", 64'(wl_v[0]), 64'(0));
    chk(0, "restart_run_count", 64'(rc_v[0]), 64'(0));
    chk(0, "restart_done", 64'(done_v[0]), 64'(0));
    chk(0, "restart_core_reset", 64'(core_reset_v[0]), 64'(1));

    // Alternating-valid load with halt_req held (must be ignored) until RELEASE.
    base = n_wr[0];
    halt_req[0] = 1'b1;
    load_prog(0, 8, 1'b1, DEP_A, 1, -1);
    halt_req[0] = 1'b0;
    chk(0, "alt_in_ready_after_last", 64'(in_ready_v[0]), 64'(0));
    chk(0, "alt_writes_count", 64'(n_wr[0] - base), 64'(8));
    wait_running(0);
    tick();
    restart[0] = 1'b1;
    tick();
    restart[0] = 1'b0;
    chk(0, "restart_ignored_in_run", 64'(running_v[0]), 64'(1));
    tick(); tick();
    halt_req[0] = 1'b1;
    tick();
    halt_req[0] = 1'b0;
    chk(0, "halt_done", 64'(done_v[0]), 64'(1));
    chk(0, "halt_running", 64'(running_v[0]), 64'(0));
    chk(0, "halt_run_count", 64'(rc_v[0]), 64'(4));
    tick();
    chk(0, "halt_run_count_held", 64'(rc_v[0]), 64'(4));

    // Reset mid-load at the third word; the next load must restart at address 0.
    pulse_restart(0);
    prog.delete();
    for (int i = 0; i < 6; i++) prog.push_back($urandom);
    base = n_wr[0];
    load_prog(0, 6, 1'b1, DEP_A, 2, 2);
    tick();
    chk(0, "abort_writes", 64'(n_wr[0] - base), 64'(2));
    chk(0, "abort_q_empty", 64'(q0.size()), 64'(0));

    len = int'($urandom_range(3, 12));
    prog.delete();
    for (int i = 0; i < len; i++) prog.push_back($urandom);
    load_prog(0, len, 1'b1, DEP_A, 2, -1);
    wait_running(0);
    chk(0, "rand_words", 64'(wl_v[0]), 64'(len));
    chk(0, "rand_release_len", 64'(run_start[0] - last_wr_cyc[0]), 64'(RST_C));
    j = int'($urandom_range(1, 15));
    repeat (j - 1) tick();
    halt_req[0] = 1'b1;
    tick();
    halt_req[0] = 1'b0;
    chk(0, "rand_halt_done", 64'(done_v[0]), 64'(1));
    chk(0, "rand_halt_count", 64'(rc_v[0]), 64'(j - 1));

    // Tiny memory: six words, no in_last, must overflow after four.
    prog.delete();
    for (int i = 0; i < 6; i++) prog.push_back($urandom);
    base = n_wr[1];
    load_prog(1, 6, 1'b0, DEP_B, 2, -1);
    tick();
    chk(1, "ovf_writes", 64'(n_wr[1] - base), 64'(DEP_B));
    chk(1, "ovf_flag", 64'(overflow_v[1]), 64'(1));
    chk(1, "ovf_words", 64'(wl_v[1]), 64'(DEP_B));
    chk(1, "ovf_in_ready", 64'(in_ready_v[1]), 64'(0));
    wait_running(1);
    chk(1, "ovf_core_reset", 64'(core_reset_v[1]), 64'(0));
    chk(1, "ovf_release_len", 64'(run_start[1] - last_wr_cyc[1]), 64'(RST_C));
    repeat (int'($urandom_range(20, 40))) tick();
    chk(1, "unbounded_running", 64'(running_v[1]), 64'(1));
    e = cyc - run_start[1];
    halt_req[1] = 1'b1;
    tick();
    halt_req[1] = 1'b0;
    chk(1, "unbounded_done", 64'(done_v[1]), 64'(1));
    chk(1, "unbounded_count", 64'(rc_v[1]), 64'(e));
    chk(1, "ovf_sticky_in_halt", 64'(overflow_v[1]), 64'(1));
    pulse_restart(1);
    chk(1, "restart_overflow", 64'(overflow_v[1]), 64'(0));
    chk(1, "restart_words", 64'(wl_v[1]), 64'(0));

    tick(); tick();
    chk(0, "q_drained", 64'(q0.size()), 64'(0));
    chk(1, "q_drained", 64'(q1.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction word width.
REQ-002 SHALL have parameter DEPTH, default 256: instruction memory depth in words, at least 2.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH): word-address width.
REQ-004 SHALL have parameter CORE_RST_CYCLES, default 2: cycles core_reset is held after the load completes, at least 1.
REQ-005 SHALL have parameter RUN_CYCLES, default 0: run-cycle budget; 0 means unlimited.
REQ-006 SHALL have ports, one per line:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  load word present.
- in_ready  output  1  loader accepts a word this cycle.
- in_data  input  DATA_W  instruction word.
- in_last  input  1  final word of the program.
- halt_req  input  1  stop the running core.
- restart  input  1  return from HALT to LOAD.
- mem_we  output  1  instruction-memory write strobe.
- mem_addr  output  ADDR_W  write word address.
- mem_wdata  output  DATA_W  write data.
- core_reset  output  1  reset to the RV32I core.
- running  output  1  state is RUN.
- done  output  1  state is HALT.
- overflow  output  1  program exceeded DEPTH.
- words_loaded  output  ADDR_W+1  count of words accepted.
- run_count  output  32  core cycles elapsed in RUN.

Function
REQ-007 SHALL implement four states, LOAD, RELEASE, RUN and HALT, with LOAD entered out of reset.
REQ-008 in_ready SHALL equal 1 only in LOAD; a word is accepted on any cycle where in_valid and in_ready are both 1.
REQ-009 An accepted word SHALL produce registered mem_we=1, mem_addr equal to the write pointer, and mem_wdata equal to in_data on the following cycle; mem_we SHALL be 0 on all other cycles.
REQ-010 The write pointer SHALL start at 0 and increment by 1 per accepted word; words_loaded SHALL track the same count.
REQ-011 An accepted word with in_last=1 SHALL move the state LOAD to RELEASE.
REQ-012 A word accepted at pointer DEPTH-1 with in_last=0 SHALL be written, SHALL set overflow=1 (sticky until reset or restart), and SHALL move the state to RELEASE; there is no pointer wrap-around.
REQ-013 core_reset SHALL be 1 in LOAD, RELEASE and HALT, and 0 only in RUN.
REQ-014 RELEASE SHALL last exactly CORE_RST_CYCLES cycles and then enter RUN.
REQ-015 In RUN, run_count SHALL increment once per cycle starting from 0 on the first RUN cycle, and SHALL saturate at 2^32-1.
REQ-016 RUN SHALL move to HALT on halt_req=1, or when RUN_CYCLES is not 0 and run_count equals RUN_CYCLES-1.
REQ-017 HALT SHALL hold run_count and words_loaded; restart=1 SHALL move the state to LOAD and clear the pointer, words_loaded, run_count and overflow.
REQ-018 halt_req SHALL be ignored outside RUN, and restart SHALL be ignored outside HALT.
REQ-019 in_valid with in_ready=0 SHALL have no effect, and no word is dropped within LOAD.

Reset
REQ-020 reset SHALL force state LOAD, pointer 0, in_ready 1, mem_we 0, mem_addr 0, mem_wdata 0, core_reset 1, running 0, done 0, overflow 0, words_loaded 0 and run_count 0.
REQ-021 reset asserted mid-load or mid-run SHALL take effect on the next edge, and SHALL suppress any pending mem_we.

Verification
REQ-022 Load 8 words 3e800093, 00300113, 00000193, 00000213, 00220863, 001181b3, 00120213 and ff5ff36f (in_last on the 8th), with no gaps. Required: mem_we on 8 consecutive cycles at addresses 0-7, words_loaded=8, core_reset low CORE_RST_CYCLES cycles after the final write strobe, overflow=0.
REQ-023 Toggle in_valid every other cycle during the load. Required: the same 8 writes with no duplicates or drops, and in_ready=0 after the last word is accepted.
REQ-024 With DEPTH=4, send 6 words with no in_last. Required: writes to addresses 0-3 only, overflow=1, in_ready=0 from word 5 onward, core_reset released.
REQ-025 With RUN_CYCLES=20, after the load. Required: running=1 for exactly 20 cycles, then done=1, core_reset=1, run_count=19 held; restart then gives LOAD with all counters 0.
REQ-026 Pulse halt_req on the 5th RUN cycle. Required: HALT on the next edge, run_count=4. Assert reset during a load at word 3. Required: all outputs at reset values, and the next load starts at address 0.
